// File: rtl/call_stack_pkg.sv
// Shared types and constants for the return-address stack: FSM state encoding
// and clock-edge selectors.
package call_stack_pkg;

  typedef enum logic {
    CS_RUN = 1'b0,
    CS_ERR = 1'b1
  } cs_state_e;

  localparam bit POS_EDGE = 1'b1;
  localparam bit NEG_EDGE = 1'b0;

endpackage

// File: rtl/call_stack_stack_ptr.sv
// Saturating up/down stack pointer. The pointer equals the number of valid entries,
// so depth, full and empty all decode straight from the register.
module stack_ptr #(
  parameter int addr_width = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                inc_i,
  input  logic                dec_i,
  input  logic                hold_i,
  output logic [addr_width:0] sp_o,
  output logic                full_o,
  output logic                empty_o
);

  localparam logic [addr_width:0] DEPTH = (addr_width+1)'(2**addr_width);

  logic [addr_width:0] sp_q;
  logic [addr_width:0] sp_d;

  // NOTE: next-state logic gets a default assignment first so no latch is inferred.
  always_comb begin
    sp_d = sp_q;
    if (clr_i) begin
      sp_d = '0;
    end else if (!hold_i) begin
      if (inc_i && !full_o)       sp_d = sp_q + (addr_width+1)'(1);
      else if (dec_i && !empty_o) sp_d = sp_q - (addr_width+1)'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sp_q <= '0;
    else      sp_q <= sp_d;
  end

  assign sp_o    = sp_q;
  assign full_o  = (sp_q == DEPTH);
  assign empty_o = (sp_q == '0);

endmodule

// File: rtl/call_stack.sv
// Hardware return-address stack for the PC path: push PC+offset on call, expose
// the registered top for rtrn, tail-call replace, and a sticky error state.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int addr_width  = 4,
  parameter int data_width  = 8,
  parameter int ret_offset  = 1,
  parameter bit active_edge = POS_EDGE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] i_PC,
  input  logic                  call,
  input  logic                  rtrn,
  input  logic                  clr,
  output logic [data_width-1:0] o_Stack,
  output logic [addr_width:0]   o_depth,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**addr_width;

  logic clk_g;
  generate
    if (active_edge == POS_EDGE) begin : g_pos
      assign clk_g = clk;
    end else begin : g_neg
      assign clk_g = ~clk;
    end
  endgenerate

  cs_state_e             state_q;
  logic [data_width-1:0] stack_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic [data_width-1:0] mem_q [DEPTH];

  logic [addr_width:0]   sp;
  logic                  sp_full;
  logic                  sp_empty;

  logic                  run;
  logic [data_width-1:0] ret_addr;
  logic                  do_replace, do_push, do_pop, ovf_hit, unf_hit;
  logic [addr_width-1:0] push_idx, top_idx, below_idx;

  assign run      = (state_q == CS_RUN) && !clr;
  assign ret_addr = i_PC + data_width'(ret_offset);

  // call+rtrn on an empty stack degenerates to a plain push
  assign do_replace = run && call && rtrn && !sp_empty;
  assign do_push    = run && call && !do_replace && !sp_full;
  assign do_pop     = run && rtrn && !call && !sp_empty;
  assign ovf_hit    = run && call && !rtrn && sp_full;
  assign unf_hit    = run && rtrn && !call && sp_empty;

  assign push_idx  = sp[addr_width-1:0];
  assign top_idx   = sp[addr_width-1:0] - addr_width'(1);
  assign below_idx = sp[addr_width-1:0] - addr_width'(2);

  stack_ptr #(.addr_width(addr_width)) u_stack_ptr (
    .clk     (clk_g),
    .rst     (rst),
    .clr_i   (clr),
    .inc_i   (do_push),
    .dec_i   (do_pop),
    .hold_i  (state_q == CS_ERR),
    .sp_o    (sp),
    .full_o  (sp_full),
    .empty_o (sp_empty)
  );

  // NOTE: storage is left unreset; entries above SP are never observed.
  always_ff @(posedge clk_g) begin
    if (do_push)         mem_q[push_idx] <= ret_addr;
    else if (do_replace) mem_q[top_idx]  <= ret_addr;
  end

  always_ff @(posedge clk_g or negedge rst) begin
    if (!rst) begin
      state_q     <= CS_RUN;
      stack_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clr) begin
      state_q     <= CS_RUN;
      stack_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (state_q == CS_RUN) begin
      if (ovf_hit) begin
        overflow_q <= 1'b1;
        state_q    <= CS_ERR;
      end else if (unf_hit) begin
        underflow_q <= 1'b1;
        state_q     <= CS_ERR;
      end else if (do_push || do_replace) begin
        stack_q <= ret_addr;
      end else if (do_pop) begin
        stack_q <= (sp == (addr_width+1)'(1)) ? '0 : mem_q[below_idx];
      end
    end
  end

  assign o_Stack   = stack_q;
  assign o_depth   = sp;
  assign full      = sp_full;
  assign empty     = sp_empty;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench for call_stack (4-entry configuration): directed vector
// table, hand-written corner sequences, and random traffic against a queue model.
module tb_call_stack;

  localparam int AW    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] i_PC;
  logic          call, rtrn, clr;
  logic [DW-1:0] o_Stack;
  logic [AW:0]   o_depth;
  logic          full, empty, overflow, underflow;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of return addresses plus sticky flags.
  logic [DW-1:0] mq[$];
  bit m_err, m_ovf, m_unf;

  call_stack #(.addr_width(AW), .data_width(DW), .ret_offset(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_PC      (i_PC),
    .call      (call),
    .rtrn      (rtrn),
    .clr       (clr),
    .o_Stack   (o_Stack),
    .o_depth   (o_depth),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_err = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_update(input logic c, input logic r, input logic cl, input logic [DW-1:0] pc);
    logic [DW-1:0] ra;
    ra = pc + 8'd1;
    if (cl) begin
      model_reset();
    end else if (!m_err) begin
      if (c && r && mq.size() > 0) begin
        mq[mq.size()-1] = ra;
      end else if (c) begin
        if (mq.size() == DEPTH) begin m_ovf = 1; m_err = 1; end
        else mq.push_back(ra);
      end else if (r) begin
        if (mq.size() == 0) begin m_unf = 1; m_err = 1; end
        else void'(mq.pop_back());
      end
    end
  endtask

  // Called at edge+1: drive inputs, let one active edge pass, settle.
  task automatic step(input logic c, input logic r, input logic cl, input logic [DW-1:0] pc);
    call = c; rtrn = r; clr = cl; i_PC = pc;
    model_update(c, r, cl, pc);
    @(posedge clk);
    #1;
    call = 0; rtrn = 0; clr = 0;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = mq.size();
    check({tag, ".o_Stack"},   32'(o_Stack),   (n > 0) ? 32'(mq[n-1]) : 32'd0);
    check({tag, ".o_depth"},   32'(o_depth),   32'(n));
    check({tag, ".full"},      32'(full),      32'(n == DEPTH));
    check({tag, ".empty"},     32'(empty),     32'(n == 0));
    check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  typedef struct {
    logic          c, r, cl;
    logic [DW-1:0] pc;
    logic [DW-1:0] e_stack;
    int            e_depth;
    logic          e_ovf, e_unf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, input logic r, input logic cl, input logic [7:0] pc,
                     input logic [7:0] es, input int ed, input logic eo, input logic eu);
    vec_t v;
    v.c = c; v.r = r; v.cl = cl; v.pc = pc;
    v.e_stack = es; v.e_depth = ed; v.e_ovf = eo; v.e_unf = eu;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b0; call = 0; rtrn = 0; clr = 0; i_PC = '0;
    model_reset();

    //   c  r  cl pc      stack  d  ovf unf
    add(1, 0, 0, 8'h10, 8'h11, 1, 0, 0);
    add(1, 0, 0, 8'h20, 8'h21, 2, 0, 0);
    add(1, 0, 0, 8'h30, 8'h31, 3, 0, 0);
    add(1, 0, 0, 8'h40, 8'h41, 4, 0, 0);
    add(1, 0, 0, 8'h50, 8'h41, 4, 1, 0);  // overflow
    add(0, 1, 0, 8'h00, 8'h41, 4, 1, 0);  // ignored in ERR
    add(1, 1, 0, 8'h60, 8'h41, 4, 1, 0);  // ignored in ERR
    add(0, 0, 1, 8'h00, 8'h00, 0, 0, 0);
    add(1, 0, 0, 8'h10, 8'h11, 1, 0, 0);
    add(1, 0, 0, 8'h20, 8'h21, 2, 0, 0);
    add(1, 1, 0, 8'h80, 8'h81, 2, 0, 0);  // tail-call replace
    add(0, 1, 0, 8'h00, 8'h11, 1, 0, 0);
    add(0, 1, 0, 8'h00, 8'h00, 0, 0, 0);
    add(1, 1, 0, 8'h70, 8'h71, 1, 0, 0);  // call+rtrn on empty = push
    add(0, 1, 0, 8'h00, 8'h00, 0, 0, 0);
    add(0, 1, 0, 8'h00, 8'h00, 0, 0, 1);  // underflow
    add(1, 0, 0, 8'h05, 8'h00, 0, 0, 1);  // ignored in ERR
    add(0, 0, 1, 8'h00, 8'h00, 0, 0, 0);
    add(1, 0, 0, 8'h05, 8'h06, 1, 0, 0);
    add(1, 0, 0, 8'hFF, 8'h00, 2, 0, 0);  // PC+1 wraps
    add(1, 0, 1, 8'h33, 8'h00, 0, 0, 0);  // clr beats call

    repeat (2) @(posedge clk);
    #1;
    check("reset.o_Stack",   32'(o_Stack),   32'd0);
    check("reset.o_depth",   32'(o_depth),   32'd0);
    check("reset.empty",     32'(empty),     32'd1);
    check("reset.full",      32'(full),      32'd0);
    check("reset.overflow",  32'(overflow),  32'd0);
    check("reset.underflow", 32'(underflow), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].c, vecs[i].r, vecs[i].cl, vecs[i].pc);
      check($sformatf("vec%0d.o_Stack", i),   32'(o_Stack),   32'(vecs[i].e_stack));
      check($sformatf("vec%0d.o_depth", i),   32'(o_depth),   32'(vecs[i].e_depth));
      check($sformatf("vec%0d.full", i),      32'(full),      32'(vecs[i].e_depth == DEPTH));
      check($sformatf("vec%0d.empty", i),     32'(empty),     32'(vecs[i].e_depth == 0));
      check($sformatf("vec%0d.overflow", i),  32'(overflow),  32'(vecs[i].e_ovf));
      check($sformatf("vec%0d.underflow", i), 32'(underflow), 32'(vecs[i].e_unf));
    end

    // Fill, then drain: top is readable during the rtrn cycle itself.
    step(1, 0, 0, 8'h10);
    step(1, 0, 0, 8'h20);
    step(1, 0, 0, 8'h30);
    step(1, 0, 0, 8'h40);
    check("fill.full", 32'(full), 32'd1);
    rtrn = 1;
    #1;
    check("pre_rtrn.o_Stack", 32'(o_Stack), 32'h41);
    step(0, 1, 0, 8'h00);
    check("pop1.o_Stack", 32'(o_Stack), 32'h31);
    step(0, 1, 0, 8'h00);
    check("pop2.o_Stack", 32'(o_Stack), 32'h21);
    step(0, 1, 0, 8'h00);
    check("pop3.o_Stack", 32'(o_Stack), 32'h11);
    step(0, 1, 0, 8'h00);
    check_model("drain");

    // call+rtrn while full is a legal replace, not an overflow.
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 8'(8'h10 * (i + 1)));
    step(1, 1, 0, 8'h99);
    check("full_replace.o_Stack",  32'(o_Stack),  32'h9A);
    check("full_replace.overflow", 32'(overflow), 32'd0);
    check_model("full_replace");

    // Async reset between edges with a call pending.
    call = 1; i_PC = 8'h33;
    #2;
    rst = 1'b0;
    #1;
    call = 0;
    model_reset();
    check_model("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_model("async_rst_hold");

    // Random traffic against the queue model.
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0), 8'($urandom));
      check_model($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/call_stack.md
# call_stack

Parametrised hardware return-address stack for the FRANK6000 program-counter path. It stores `i_PC + ret_offset` on `call` and presents the current top entry on `o_Stack` for `rtrn`. It also supports a same-cycle call+return replace (tail call) and reports full/empty status and depth. Overflow and underflow are caught by a sticky error state instead of wrapping silently. It sits between the instruction decoder (`call`/`rtrn`) and the PC mux.

## Interface
- `addr_width`, 4: stack pointer width; depth = 2**`addr_width` entries
- `data_width`, 8: PC / entry width
- `ret_offset`, 1: constant added to `i_PC` on push
- `active_edge`, `` `POS_EDGE ``: clock edge used (`` `POS_EDGE `` / `` `NEG_EDGE ``, per `edge_macro.v`)
- `clk`  in  1  clock; single clock domain
- `rst`  in  1  reset; asynchronous, active-low
- `i_PC`  in  `data_width`  current program counter
- `call`  in  1  push return address
- `rtrn`  in  1  pop top entry
- `clr`  in  1  synchronous flush: empties the stack and clears errors
- `o_Stack`  out  `data_width`  registered top-of-stack; 0 when empty
- `o_depth`  out  `addr_width`+1  number of valid entries, 0..2**`addr_width`
- `full`  out  1  `o_depth` == 2**`addr_width`
- `empty`  out  1  `o_depth` == 0
- `overflow`  out  1  sticky; set by a call while full
- `underflow`  out  1  sticky; set by a rtrn while empty

## Operation
- FSM states: `RUN`, `ERR`. Reset state is `RUN`.
- Reset (`rst`=0, async): SP=0, `o_Stack`=0, `o_depth`=0, `empty`=1, `full`=0, `overflow`=0, `underflow`=0, state `RUN`. Storage contents are don't-care.
- Input priority per active edge: `clr` > error checks > call+rtrn > call > rtrn.
- `clr`: SP=0, flags cleared, state `RUN`, `o_Stack`=0. Valid in either state.
- In `RUN`:
  - call only, not full: `mem[SP]` = `i_PC`+`ret_offset` (mod 2**`data_width`); SP+1; `o_Stack` = pushed value.
  - rtrn only, not empty: SP-1; `o_Stack` = `mem[SP-2]`, or 0 if the new depth is 0.
  - call+rtrn, not empty: `mem[SP-1]` overwritten with `i_PC`+`ret_offset`; SP unchanged; `o_Stack` = new value.
  - call+rtrn while empty: treated as call only.
  - call while full (without rtrn): no write, SP held, `overflow`=1, go to `ERR`. call+rtrn while full is a legal replace.
  - rtrn while empty (without call): SP held, `underflow`=1, go to `ERR`.
- In `ERR`: call/rtrn ignored; SP, storage and `o_Stack` frozen; only `clr` or `rst` exits.
- SP never wraps. Depth arithmetic uses `addr_width`+1 bits.

## Timing
- All state updates happen on the active edge of `clk`; `rst` acts immediately.
- `o_Stack` is valid during the cycle `rtrn` is asserted, so the PC mux can load the return address from it combinationally in that cycle. After the edge it shows the new top.
- Push latency is 1 edge: the pushed value appears on `o_Stack` after the `call` edge.
- `full`, `empty` and `o_depth` are decoded from the registered SP: no combinational path from `call`/`rtrn`.
- `overflow`/`underflow` assert the edge after the offending request and stay asserted until `clr`/`rst`.
- Reset asserted mid-sequence discards all entries. Back-to-back call/rtrn on every cycle is supported with no bubbles.

## Structure
- `call_stack_defs.vh` (shared include): FSM state encodings `CS_RUN`/`CS_ERR`. Reuses `edge_macro.v`.
- Storage is a flop array inside `call_stack`, for async reset and a two-entry read (top and top-1).
- One sub-module, `stack_ptr`: saturating up/down counter producing SP, `o_depth`, `full`, `empty`, with hold and clear inputs.

## Test plan
- `addr_width`=2: reset, then call with `i_PC`=0x10,0x20,0x30,0x40 -> `o_Stack`=0x11,0x21,0x31,0x41; `full`=1; `o_depth`=4.
- From full, 4×rtrn -> `o_Stack` shows 0x41 during the first rtrn, then 0x31, 0x21, 0x11, 0; `empty`=1, no error.
- Depth 2 with top 0x21; call+rtrn with `i_PC`=0x80 -> `o_depth`=2, `o_Stack`=0x81; a following rtrn -> `o_Stack`=0x11.
- Full stack, one more call -> `overflow`=1, state `ERR`, `o_Stack` stays 0x41; later call/rtrn ignored; `clr` -> `o_depth`=0, flags 0.
- Empty stack, rtrn -> `underflow`=1; then call with 0x05 ignored (`o_depth`=0); `clr`, then call with 0x05 -> `o_Stack`=0x06.
- `i_PC`=0xFF, call -> `o_Stack`=0x00 (wrap). Assert `rst` low mid-push between edges -> all outputs immediately take their reset values.
